// File: rtl/bram_uart_streamer_pkg.sv
// Shared state encoding, header constants and word sizing for the frame streamer.
// The HDR state exists only when BRAM_UART_STREAMER_HEADER_EN is defined.
package streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_LOAD,
    S_PULSE,
    S_GUARD,
    S_NEXT,
    S_DONE
`ifdef BRAM_UART_STREAMER_HEADER_EN
    , S_HDR
`endif
  } state_e;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  function automatic int BYTES_PER_WORD(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bram_uart_streamer_timer.sv
// Read-latency timer: reloads while load_i is high, then expire_o rises RD_LAT cycles after load_i drops.
module rd_latency_timer #(
  parameter int RD_LAT = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(RD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= CNT_W'(RD_LAT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/bram_uart_streamer.sv
// Streams a window of a synchronous-read memory into a byte UART, MSB byte first.
// Optional 4-byte frame header (A5 5A NUM_WORDS[15:0]) under BRAM_UART_STREAMER_HEADER_EN.
module bram_uart_streamer
  import streamer_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 3969,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_enable_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int               BPW     = BYTES_PER_WORD(DATA_W);
  localparam int               BCNT_W  = $clog2(BPW) + 1;
  localparam logic [ADDR_W:0]  LAST_WC = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

  generate
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
      $error("bram_uart_streamer: DATA_W must be a non-zero multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("bram_uart_streamer: RD_LAT must be in 1..15");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W)) begin : g_bad_num_words
      $error("bram_uart_streamer: NUM_WORDS must be in 1..2^ADDR_W");
    end
  endgenerate

  state_e              state_q;
  logic                start_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [7:0]          tx_data_q;
  logic                tx_en_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W:0]     wc_q;
  logic [ADDR_W:0]     wc_inc;
  logic [DATA_W-1:0]   sh_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                start_rise;
  logic                rd_valid;

`ifdef BRAM_UART_STREAMER_HEADER_EN
  localparam logic [15:0] NW16 = 16'(NUM_WORDS);

  logic [1:0] hdr_idx_q;
  logic       hdr_act_q;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SYNC0;
      2'd1:    return SYNC1;
      2'd2:    return NW16[15:8];
      default: return NW16[7:0];
    endcase
  endfunction
`endif

  assign start_rise = start_i & ~start_q;
  assign wc_inc     = wc_q + 1'b1;

  // Timer is held loaded outside RD_WAIT, so it always counts from the first RD_WAIT cycle.
  rd_latency_timer #(
    .RD_LAT(RD_LAT)
  ) u_rd_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (state_q != S_RD_WAIT),
    .expire_o(rd_valid)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      rd_addr_q <= BASE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wc_q      <= '0;
      sh_q      <= '0;
      bcnt_q    <= '0;
`ifdef BRAM_UART_STREAMER_HEADER_EN
      hdr_idx_q <= '0;
      hdr_act_q <= 1'b0;
`endif
    end else begin
      start_q <= start_i;
      tx_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            wc_q      <= '0;
            done_q    <= 1'b0;
            rd_addr_q <= BASE;
            busy_q    <= 1'b1;
`ifdef BRAM_UART_STREAMER_HEADER_EN
            hdr_idx_q <= '0;
            hdr_act_q <= 1'b1;
            state_q   <= S_HDR;
`else
            state_q   <= S_RD_WAIT;
`endif
          end
        end
`ifdef BRAM_UART_STREAMER_HEADER_EN
        S_HDR: begin
          sh_q    <= DATA_W'(hdr_byte(hdr_idx_q)) << (DATA_W - 8);
          bcnt_q  <= BCNT_W'(1);
          state_q <= S_LOAD;
        end
`endif
        S_RD_WAIT: begin
          if (rd_valid) begin
            sh_q    <= rd_data_i;
            bcnt_q  <= BCNT_W'(BPW);
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!tx_busy_i) begin
            tx_data_q <= sh_q[DATA_W-1 -: 8];
            tx_en_q   <= 1'b1;
            state_q   <= S_PULSE;
          end
        end
        S_PULSE: begin
          state_q <= S_GUARD;
        end
        S_GUARD: begin
          sh_q   <= sh_q << 8;
          bcnt_q <= bcnt_q - 1'b1;
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef BRAM_UART_STREAMER_HEADER_EN
            hdr_act_q <= 1'b0;
`endif
          end else if (bcnt_q != BCNT_W'(1)) begin
            state_q <= S_LOAD;
`ifdef BRAM_UART_STREAMER_HEADER_EN
          end else if (hdr_act_q) begin
            if (hdr_idx_q == 2'd3) begin
              hdr_act_q <= 1'b0;
              state_q   <= S_RD_WAIT;
            end else begin
              hdr_idx_q <= hdr_idx_q + 2'd1;
              state_q   <= S_HDR;
            end
`endif
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          wc_q <= wc_inc;
          if (wc_inc == LAST_WC) begin
            state_q <= S_DONE;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            state_q   <= S_RD_WAIT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr_o    = rd_addr_q;
  assign tx_data_o    = tx_data_q;
  assign tx_enable_o  = tx_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_bram_uart_streamer.sv
// Bench for bram_uart_streamer: 24-bit words, 200-word frame starting just below the address wrap.
module tb_bram_uart_streamer;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 24;
  localparam int NUM_WORDS = 200;
  localparam int BASE_ADDR = 4094;
  localparam int RD_LAT    = 3;
  localparam int TX_CYC    = 10;
  localparam int BPW       = DATA_W / 8;
`ifdef BRAM_UART_STREAMER_HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, abort, tx_busy, tx_enable, busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  bram_uart_streamer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .BASE_ADDR(BASE_ADDR),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .abort_i     (abort),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .tx_data_o   (tx_data),
    .tx_enable_o (tx_enable),
    .tx_busy_i   (tx_busy),
    .busy_o      (busy),
    .done_o      (done),
    .word_count_o(word_count)
  );

  // Memory with RD_LAT cycles of address-to-data latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] apipe [RD_LAT];
  always @(posedge clk) begin
    apipe[0] <= rd_addr;
    for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign rd_data = mem[apipe[RD_LAT-1]];

  // Transmitter: busy for TX_CYC cycles after each strobe; ignores DUT reset.
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (tx_enable) tx_cnt <= TX_CYC;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = (tx_cnt != 0);

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_tx = 0;
  logic       prev_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (tx_enable === 1'b1) begin
      n_tx++;
      got_q.push_back(tx_data);
      chk("tx_enable while tx_busy", 32'(tx_busy), 32'd0);
      chk("tx_enable back-to-back", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected tx byte: got %0h, expected no transmission", tx_data);
      end else begin
        chk("tx byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_en <= (tx_enable === 1'b1);
  end

  task automatic push_frame();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    got_q.delete();
`ifdef BRAM_UART_STREAMER_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(NUM_WORDS >> 8));
    exp_q.push_back(8'(NUM_WORDS));
`endif
    for (int i = 0; i < NUM_WORDS; i++) begin
      a = ADDR_W'(BASE_ADDR + i);
      w = mem[a];
      for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'(BASE_ADDR));
    chk({tag, " tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, " tx_enable"}, 32'(tx_enable), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " word_count"}, 32'(word_count), 32'd0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic [7:0]        b0, b1, b2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [ADDR_W-1:0] off;
    int idx, n, snap;

    vecs[0] = '{12'hFFE, 24'h123456, 8'h12, 8'h34, 8'h56};
    vecs[1] = '{12'hFFF, 24'hABCDEF, 8'hAB, 8'hCD, 8'hEF};
    vecs[2] = '{12'h000, 24'hFF0080, 8'hFF, 8'h00, 8'h80};
    vecs[3] = '{12'h001, 24'h01FE7F, 8'h01, 8'hFE, 8'h7F};
    vecs[4] = '{12'h0C5, 24'hC0FFEE, 8'hC0, 8'hFF, 8'hEE};

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 24'((i * 24'h00A3B1) ^ 24'h5C3A17);
    for (int i = 0; i < 5; i++) mem[vecs[i].addr] = vecs[i].word;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Frame 1: full run, byte order and wrap checked against the vector table.
    push_frame();
    start = 1'b1;
    @(negedge clk);
    chk("f1 busy after start edge", 32'(busy), 32'd1);
    chk("f1 rd_addr at start", 32'(rd_addr), 32'(BASE_ADDR));
    wait_done("f1 done", 20000);
    chk("f1 word_count", 32'(word_count), 32'(NUM_WORDS));
    chk("f1 busy after done", 32'(busy), 32'd0);
    chk("f1 bytes outstanding", 32'(exp_q.size()), 32'd0);
    chk("f1 byte total", 32'(got_q.size()), 32'(HDR_N + BPW * NUM_WORDS));
`ifdef BRAM_UART_STREAMER_HEADER_EN
    chk("hdr sync0", 32'(got_q[0]), 32'hA5);
    chk("hdr sync1", 32'(got_q[1]), 32'h5A);
    chk("hdr len hi", 32'(got_q[2]), 32'h00);
    chk("hdr len lo", 32'(got_q[3]), 32'hC8);
`endif
    for (int i = 0; i < 5; i++) begin
      off = vecs[i].addr - ADDR_W'(BASE_ADDR);
      idx = HDR_N + BPW * int'(off);
      chk($sformatf("vec%0d byte0", i), 32'(got_q[idx]), 32'(vecs[i].b0));
      chk($sformatf("vec%0d byte1", i), 32'(got_q[idx+1]), 32'(vecs[i].b1));
      chk($sformatf("vec%0d byte2", i), 32'(got_q[idx+2]), 32'(vecs[i].b2));
    end

    // start still high: no retrigger.
    snap = n_tx;
    repeat (100) @(negedge clk);
    chk("held start busy", 32'(busy), 32'd0);
    chk("held start done", 32'(done), 32'd1);
    chk("held start tx count", 32'(n_tx), 32'(snap));

    // New edge, then abort while a word-5 byte is on the wire.
    start = 1'b0;
    @(negedge clk);
    push_frame();
    start = 1'b1;
    @(negedge clk);
    chk("f2 busy", 32'(busy), 32'd1);
    chk("f2 done cleared", 32'(done), 32'd0);
    n = 0;
    while (!(tx_enable === 1'b1 && word_count == 5) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("f2 reached word 5", 32'(tx_enable === 1'b1 && word_count == 5), 32'd1);
    abort = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    exp_q.delete();
    snap = n_tx;
    repeat (60) @(negedge clk);
    chk("abort no further tx", 32'(n_tx), 32'(snap));
    chk("abort word_count", 32'(word_count), 32'd5);
    chk("abort done", 32'(done), 32'd0);

    // Reset in RD_WAIT of word 100.
    start = 1'b0;
    @(negedge clk);
    push_frame();
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (word_count != 100 && n < 10000);
    chk("f3 reached word 100", 32'(word_count), 32'd100);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-frame reset");
    reset = 1'b0;
    exp_q.delete();
    snap = n_tx;
    repeat (20) @(negedge clk);
    chk("post reset idle tx", 32'(n_tx), 32'(snap));

    push_frame();
    start = 1'b1;
    @(negedge clk);
    chk("f4 busy", 32'(busy), 32'd1);
    chk("f4 rd_addr", 32'(rd_addr), 32'(BASE_ADDR));
    wait_done("f4 done", 20000);
    chk("f4 word_count", 32'(word_count), 32'(NUM_WORDS));
    chk("f4 bytes outstanding", 32'(exp_q.size()), 32'd0);
    chk("f4 first byte", 32'(got_q[HDR_N]), 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
